// File: rtl/mem_stream_reader.sv
// mem_stream_reader
// Reads one frame of 2**ADDR_W words from a memory with a combinational read
// port and emits it as a valid/ready stream with a last marker. One output
// register stage holds the current word; a new word is loaded whenever that
// register is empty or being consumed, so a full-rate consumer sees one word
// per cycle.
//
// Ports
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : one-cycle request to read out a frame (ignored while busy)
//   abort          : synchronous frame cancel, no done pulse
//   read_add       : address to the memory read port
//   read_data      : memory read data, valid in the same cycle as read_add
//   out_data/valid/ready/last : output stream
//   busy           : high while not IDLE
//   done           : one-cycle pulse after the last word is accepted
//
// Configuration
//   MEM_STREAM_READER_BITREV_EN : when defined, words are read in bit-reversed
//   address order; otherwise in linear order.

module mem_stream_reader #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] read_add,
   input  logic [DATA_W-1:0] read_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   localparam logic [ADDR_W-1:0] LAST_CNT = {ADDR_W{1'b1}};

   function automatic logic [ADDR_W-1:0] addr_map(input logic [ADDR_W-1:0] c);
      logic [ADDR_W-1:0] r;
`ifdef MEM_STREAM_READER_BITREV_EN
      for (int i = 0; i < ADDR_W; i++) r[i] = c[ADDR_W-1-i];
`else
      r = c;
`endif
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic                done_q, done_d;
   logic                load, hs;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;

      // Output register refills when empty or being consumed this edge.
      load = (state_q == READ) && (!out_valid_q || out_ready);
      hs   = out_valid_q && out_ready;

      if (hs && !load) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d   = '0;
               state_d = READ;
            end
         end
         READ: begin
            if (load) begin
               out_data_d  = read_data;
               out_valid_d = 1'b1;
               out_last_d  = (cnt_q == LAST_CNT);
               // cnt stops at the last word so it never wraps inside a frame
               if (cnt_q == LAST_CNT) state_d = DRAIN;
               else                   cnt_d   = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (hs) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d     = IDLE;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         done_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

   // Outside READ the address parks at the first word of the frame.
   assign read_add  = (state_q == READ) ? addr_map(cnt_q) : addr_map('0);
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: directed scenarios with literal expectations
// plus a randomized phase, all checked by a frame-level scoreboard.
module tb_mem_stream_reader;
   localparam int DW = 32;
   localparam int AW = 3;
   localparam int N  = 8;

   logic          clk = 1'b0;
   logic          rst_n, start, abort, out_ready;
   logic [AW-1:0] read_add;
   logic [DW-1:0] read_data, out_data;
   logic          out_valid, out_last, busy, done;

   logic [DW-1:0] mem [N];
   logic [DW-1:0] lit [N];

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   assign read_data = mem[read_add];

   mem_stream_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .read_add(read_add), .read_data(read_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   // Position k of a frame comes from this memory index.
   function automatic int map_idx(input int k);
      int r;
`ifdef MEM_STREAM_READER_BITREV_EN
      r = 0;
      for (int b = 0; b < AW; b++) if (((k >> b) & 1) != 0) r = r + (1 << (AW - 1 - b));
`else
      r = k;
`endif
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      compared++;
      mismatched++;
      $display("FAIL %s: cycle budget expired at %0t", nm, $time);
   endtask

   // ---------------- scoreboard ----------------
   logic          sb_en = 1'b0;
   logic [DW:0]   exp_q [$];      // {last, data}
   logic          m_busy = 1'b0;
   logic          m_done = 1'b0;
   logic          stall_p = 1'b0;
   logic [DW-1:0] stall_d;
   logic          mb0;

   always @(negedge clk) begin
      if (sb_en) begin
         chk("sb_busy", busy, m_busy);
         chk("sb_done", done, m_done);
         if (!m_busy) chk("sb_valid_idle", out_valid, 0);
         if (stall_p) begin
            chk("sb_stall_valid", out_valid, 1);
            chk("sb_stall_data", out_data, stall_d);
         end
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL sb_extra_word: got %0h expected no word", out_data);
            end else begin
               chk("sb_data", out_data, exp_q[0][DW-1:0]);
               chk("sb_last", out_last, exp_q[0][DW]);
            end
         end else begin
            chk("sb_last_novalid", out_last, 0);
         end

         // advance the frame model over the coming edge
         mb0     = m_busy;
         stall_p = out_valid && !out_ready && rst_n && !abort;
         stall_d = out_data;
         m_done  = 1'b0;
         if (!rst_n || abort) begin
            m_busy  = 1'b0;
            stall_p = 1'b0;
            exp_q.delete();
         end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
               if (exp_q[0][DW]) begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
               end
               void'(exp_q.pop_front());
            end
            if (start && !mb0) begin
               m_busy = 1'b1;
               for (int k = 0; k < N; k++) exp_q.push_back({(k == N - 1), mem[map_idx(k)]});
            end
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      start = 1'b0; abort = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
      n = 0;
      while ((busy !== 1'b0 || done !== 1'b0) && n < 40) begin
         step();
         n++;
      end
      if (n >= 40) timeout("wait_idle");
   endtask

   initial begin
      int hs, n;
`ifdef MEM_STREAM_READER_BITREV_EN
      lit = '{32'h100, 32'h104, 32'h102, 32'h106, 32'h101, 32'h105, 32'h103, 32'h107};
`else
      lit = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107};
`endif
      for (int i = 0; i < N; i++) mem[i] = 32'h100 + i;
      rst_n = 1'b0; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
      step(); step();
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", read_add, 0);
      start = 1'b0;
      sb_en = 1'b1;
      rst_n = 1'b1;
      step();
      chk("post_rst_valid", out_valid, 0);

      // full-rate frame, literal order and latency
      start = 1'b1;
      step();
      start = 1'b0;
      chk("lat_e0_valid", out_valid, 0);
      chk("lat_e0_busy", busy, 1);
      for (int c = 1; c <= N; c++) begin
         step();
         chk("frame_valid", out_valid, 1);
         chk("frame_data", out_data, lit[c-1]);
         chk("frame_last", out_last, (c == N));
         chk("frame_done_early", done, 0);
      end
      chk("drain_addr", read_add, 0);
      step();
      chk("frame_done", done, 1);
      chk("frame_end_valid", out_valid, 0);
      chk("frame_end_busy", busy, 0);
      step();
      chk("frame_done_once", done, 0);

      // ready pattern 1,0,0,1
      start = 1'b1;
      step();
      start = 1'b0;
      hs = 0; n = 0;
      while (done !== 1'b1 && n < 80) begin
         out_ready = (n % 4 == 0) || (n % 4 == 3);
         if (out_valid && out_ready) hs++;
         step();
         n++;
      end
      if (n >= 80) timeout("stall_frame");
      chk("stall_hs_count", hs, N);
      wait_idle();

      // abort after the 3rd handshake
      start = 1'b1;
      step();
      start = 1'b0;
      hs = 0; n = 0;
      while (hs < 3 && n < 20) begin
         if (out_valid && out_ready) hs++;
         step();
         n++;
      end
      if (n >= 20) timeout("abort_wait");
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_last", out_last, 0);
      chk("abort_done", done, 0);
      step();
      chk("abort_no_done", done, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("abort_restart_data", out_data, mem[map_idx(0)]);
      wait_idle();

      // reset mid-frame while stalled
      out_ready = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("midrst_pre_valid", out_valid, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_last", out_last, 0);
      chk("midrst_data", out_data, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      step();
      chk("midrst_release_valid", out_valid, 0);
      out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("midrst_restart_data", out_data, mem[map_idx(0)]);
      wait_idle();

      // start during READ ignored, start in done cycle accepted
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) timeout("done_wait");
      start = 1'b1;
      step();
      start = 1'b0;
      chk("done_start_busy", busy, 1);
      chk("done_start_valid", out_valid, 0);
      step();
      chk("done_start_valid2", out_valid, 1);
      chk("done_start_data", out_data, mem[map_idx(0)]);
      wait_idle();

      // randomized traffic
      for (int blk = 0; blk < 4; blk++) begin
         wait_idle();
         for (int i = 0; i < N; i++) mem[i] = $urandom;
         for (int cyc = 0; cyc < 600; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 99) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            step();
         end
      end
      wait_idle();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
